lpc_io_responder: RTL and testbench

//  Peripheral-side LPC I/O cycle sequencer that pairs with the LPC address decoder.

---
 rtl/lpc_io_responder.sv | 215 +++++++++++++++++++++
 tb/tb_lpc_io_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_responder.sv
// lpc_io_responder
// Peripheral-side LPC I/O cycle sequencer. After the address decoder reports a
// hit, this block follows the host data/TAR nibbles, requests the access from
// the register file, drives SYNC (wait/ready/error), the read data and the
// peripheral TAR, then hands the bus back. A host abort (LpcFrame low while
// busy) returns it to idle at the next edge.
module lpc_io_responder #(
  parameter int          WAIT_MAX    = 8,     // wait-SYNC cycles before error SYNC (1..255)
  parameter logic [3:0]  WAIT_NIBBLE = 4'h6   // 4'h6 long wait, 4'h5 short wait
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LpcFrame,
  input  logic       AddrHit,
  input  logic       Opcode,
  input  logic       RegAck,
  input  logic [7:0] RegRdData,
  output logic       RegReq,
  output logic       RegWr,
  output logic [3:0] LpcBusOut,
  output logic       LpcBusOe,
  output logic       Busy,
  output logic       SyncErr
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StHData0   = 4'd1,
    StHData1   = 4'd2,
    StHTar0    = 4'd3,
    StHTar1    = 4'd4,
    StSync     = 4'd5,
    StSyncWait = 4'd6,
    StSyncOk   = 4'd7,
    StSyncErr  = 4'd8,
    StData0    = 4'd9,
    StData1    = 4'd10,
    StPTar0    = 4'd11,
    StPTar1    = 4'd12
  } stateT;

  // Last WaitCnt value seen in SyncWait before giving up.
  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  localparam logic [3:0] SyncReady = 4'h0;
  localparam logic [3:0] SyncError = 4'hA;
  localparam logic [3:0] BusIdle   = 4'hF;

  stateT      State;
  logic       AckSeen;
  logic [7:0] WaitCnt;
  logic [7:0] RdLatch;
  logic       IsWrite;

  stateT      stateNext;
  logic       ackSeenNext;
  logic [7:0] waitCntNext;
  logic [7:0] rdLatchNext;
  logic       isWriteNext;
  logic       regReqNext;
  logic       regWrNext;
  logic [3:0] busOutNext;
  logic       busOeNext;
  logic       syncErrNext;
  logic       ackValid;

  // An acknowledge only counts while a request is actually outstanding.
  assign ackValid = RegAck & RegReq;

  // Next-state and handshake bookkeeping for the I/O cycle.
  always_comb begin
    stateNext   = State;
    ackSeenNext = AckSeen | ackValid;
    waitCntNext = WaitCnt;
    rdLatchNext = ackValid ? RegRdData : RdLatch;
    isWriteNext = IsWrite;
    regReqNext  = RegReq & ~ackValid;
    regWrNext   = RegWr;

    if ((State != StIdle) && !LpcFrame) begin
      // Host abort: drop everything and wait for the next frame.
      stateNext   = StIdle;
      ackSeenNext = 1'b0;
      waitCntNext = 8'd0;
      regReqNext  = 1'b0;
    end else begin
      case (State)
        StIdle: begin
          if (AddrHit) begin
            isWriteNext = Opcode;
            ackSeenNext = 1'b0;
            waitCntNext = 8'd0;
            if (Opcode) begin
              stateNext = StHData0;
            end else begin
              // Reads skip the host data phase and request immediately.
              stateNext  = StHTar0;
              regReqNext = 1'b1;
              regWrNext  = 1'b0;
            end
          end else begin
            stateNext = StIdle;
          end
        end
        StHData0: stateNext = StHData1;
        StHData1: begin
          stateNext  = StHTar0;
          regReqNext = 1'b1;
          regWrNext  = IsWrite;
        end
        StHTar0: stateNext = StHTar1;
        StHTar1: stateNext = StSync;
        StSync: begin
          if (ackSeenNext) begin
            stateNext = StSyncOk;
          end else begin
            stateNext   = StSyncWait;
            waitCntNext = WaitCnt + 8'd1;
          end
        end
        StSyncWait: begin
          if (ackValid) begin
            // An ack on the timeout edge still wins.
            stateNext = StSyncOk;
          end else if (WaitCnt >= WaitLast) begin
            stateNext   = StSyncErr;
            regReqNext  = 1'b0;
            rdLatchNext = 8'hFF;
          end else begin
            waitCntNext = WaitCnt + 8'd1;
          end
        end
        StSyncOk:  stateNext = IsWrite ? StPTar0 : StData0;
        StSyncErr: stateNext = IsWrite ? StPTar0 : StData0;
        StData0:   stateNext = StData1;
        StData1:   stateNext = StPTar0;
        StPTar0:   stateNext = StPTar1;
        StPTar1:   stateNext = StIdle;
        default:   stateNext = StIdle;
      endcase
    end
  end

  // Bus drive values for the state being entered, so the outputs can be registered.
  always_comb begin
    busOutNext  = BusIdle;
    busOeNext   = 1'b0;
    syncErrNext = 1'b0;
    case (stateNext)
      StSync: begin
        busOeNext  = 1'b1;
        busOutNext = ackSeenNext ? SyncReady : WAIT_NIBBLE;
      end
      StSyncWait: begin
        busOeNext  = 1'b1;
        busOutNext = WAIT_NIBBLE;
      end
      StSyncOk: begin
        busOeNext  = 1'b1;
        busOutNext = SyncReady;
      end
      StSyncErr: begin
        busOeNext   = 1'b1;
        busOutNext  = SyncError;
        syncErrNext = 1'b1;
      end
      StData0: begin
        busOeNext  = 1'b1;
        busOutNext = rdLatchNext[3:0];
      end
      StData1: begin
        busOeNext  = 1'b1;
        busOutNext = rdLatchNext[7:4];
      end
      StPTar0: begin
        busOeNext  = 1'b1;
        busOutNext = BusIdle;
      end
      default: begin
        busOeNext  = 1'b0;
        busOutNext = BusIdle;
      end
    endcase
  end

  // State, handshake registers and registered bus outputs.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      State     <= StIdle;
      AckSeen   <= 1'b0;
      WaitCnt   <= 8'd0;
      RdLatch   <= 8'h00;
      IsWrite   <= 1'b0;
      RegReq    <= 1'b0;
      RegWr     <= 1'b0;
      LpcBusOut <= BusIdle;
      LpcBusOe  <= 1'b0;
      Busy      <= 1'b0;
      SyncErr   <= 1'b0;
    end else begin
      State     <= stateNext;
      AckSeen   <= ackSeenNext;
      WaitCnt   <= waitCntNext;
      RdLatch   <= rdLatchNext;
      IsWrite   <= isWriteNext;
      RegReq    <= regReqNext;
      RegWr     <= regWrNext;
      LpcBusOut <= busOutNext;
      LpcBusOe  <= busOeNext;
      Busy      <= (stateNext != StIdle);
      SyncErr   <= syncErrNext;
    end
  end

endmodule

// File: tb/tb_lpc_io_responder.sv
// Directed bench for lpc_io_responder: a per-cycle vector table for the
// basic read/write sequences plus hand-written timeout, abort and reset runs.
module tb_lpc_io_responder;

  logic       LpcClock = 1'b0;
  logic       PciReset;
  logic       LpcFrame;
  logic       AddrHit;
  logic       Opcode;
  logic       RegAck;
  logic [7:0] RegRdData;
  logic       RegReq;
  logic       RegWr;
  logic [3:0] LpcBusOut;
  logic       LpcBusOe;
  logic       Busy;
  logic       SyncErr;

  int nChecks = 0;
  int nFail   = 0;

  lpc_io_responder #(.WAIT_MAX(8), .WAIT_NIBBLE(4'h6)) dut (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .LpcFrame (LpcFrame),
    .AddrHit  (AddrHit),
    .Opcode   (Opcode),
    .RegAck   (RegAck),
    .RegRdData(RegRdData),
    .RegReq   (RegReq),
    .RegWr    (RegWr),
    .LpcBusOut(LpcBusOut),
    .LpcBusOe (LpcBusOe),
    .Busy     (Busy),
    .SyncErr  (SyncErr)
  );

  always #15 LpcClock = ~LpcClock;

  // Inputs for one edge and the outputs expected right after it.
  // wr is only compared while req is expected high.
  typedef struct {
    logic       hit;
    logic       op;
    logic       ack;
    logic [7:0] rd;
    logic [3:0] bus;
    logic       oe;
    logic       busy;
    logic       req;
    logic       wr;
    logic       err;
  } vecT;

  vecT vecs[$];
  logic [3:0] obsBus[$];
  logic [3:0] expBus[$];
  int errPulses;
  int reqAtErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic hit, input logic op, input logic ack, input logic [7:0] rd,
                        input logic [3:0] bus, input logic oe, input logic busy,
                        input logic req, input logic wr, input logic err);
    vecT v;
    v.hit = hit; v.op = op; v.ack = ack; v.rd = rd;
    v.bus = bus; v.oe = oe; v.busy = busy; v.req = req; v.wr = wr; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic checkSeq(input string name);
    check({name, " length"}, obsBus.size(), expBus.size());
    for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
      check($sformatf("%s nibble %0d", name, i), {28'd0, obsBus[i]}, {28'd0, expBus[i]});
    end
  endtask

  // Read cycle from IDLE. ackAt: ack after the n-th wait nibble (-1 none).
  // abortAt: LpcFrame low after the n-th wait nibble (-1 none).
  task automatic runRead(input int ackAt, input logic [7:0] ackData, input bit lateAck, input int abortAt);
    int  sixes;
    int  cyc;
    bit  done;
    bit  aborted;
    obsBus.delete();
    errPulses = 0;
    reqAtErr  = 0;
    sixes     = 0;
    cyc       = 0;
    done      = 1'b0;
    aborted   = 1'b0;
    @(negedge LpcClock);
    AddrHit = 1'b1; Opcode = 1'b0;
    @(posedge LpcClock); #1;
    while (!done && cyc < 60) begin
      if (LpcBusOe) obsBus.push_back(LpcBusOut);
      if (SyncErr) begin
        errPulses++;
        if (RegReq) reqAtErr++;
      end
      if (LpcBusOe && LpcBusOut == 4'h6) sixes++;
      @(negedge LpcClock);
      AddrHit = 1'b0; RegAck = 1'b0; LpcFrame = 1'b1;
      if (LpcBusOe && LpcBusOut == 4'h6 && sixes == ackAt) begin
        RegAck = 1'b1; RegRdData = ackData;
      end
      if (SyncErr && lateAck) begin
        RegAck = 1'b1; RegRdData = 8'h3C;
      end
      if (LpcBusOe && LpcBusOut == 4'h6 && sixes == abortAt) begin
        LpcFrame = 1'b0; aborted = 1'b1;
      end
      @(posedge LpcClock); #1;
      cyc++;
      if (aborted) begin
        check("abort outputs {bus,oe,busy,req}", {LpcBusOut, LpcBusOe, Busy, RegReq}, {4'hF, 1'b0, 1'b0, 1'b0});
        done = 1'b1;
      end else if (!Busy) begin
        done = 1'b1;
      end else begin
        done = 1'b0;
      end
    end
    check("read cycle completes within budget", {31'd0, done}, 32'd1);
    @(negedge LpcClock);
    RegAck = 1'b0; LpcFrame = 1'b1; AddrHit = 1'b0;
  endtask

  initial begin
    PciReset  = 1'b0;
    LpcFrame  = 1'b1;
    AddrHit   = 1'b0;
    Opcode    = 1'b0;
    RegAck    = 1'b0;
    RegRdData = 8'h00;

    // Vector table: hit op ack rd | bus oe busy req wr err
    // Ack while idle must be ignored.
    addVec(1'b0, 1'b0, 1'b1, 8'h77, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Minimum-latency read, ack in HTAR0, data A5; AddrHit during DATA0 ignored.
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // cycle 0 HTAR0
    addVec(1'b0, 1'b0, 1'b1, 8'hA5, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 1 HTAR1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 2 SYNC
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 3 SYNC_OK
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 4 DATA0
    addVec(1'b1, 1'b1, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 5 DATA1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 6 PTAR0
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 7 PTAR1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 8 IDLE
    // Write, ack 3 cycles after RegReq rises; AddrHit during HDATA0 ignored.
    addVec(1'b1, 1'b1, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 0 HDATA0
    addVec(1'b1, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 1 HDATA1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // 2 HTAR0
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // 3 HTAR1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // 4 SYNC
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // 5 SYNC_WAIT
    addVec(1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 6 SYNC_OK
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 7 PTAR0
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 8 PTAR1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 9 IDLE
    // Minimum-latency write, ack in HTAR0.
    addVec(1'b1, 1'b1, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 0 HDATA0
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 1 HDATA1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // 2 HTAR0
    addVec(1'b0, 1'b0, 1'b1, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 3 HTAR1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 4 SYNC
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 5 SYNC_OK
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // 6 PTAR0
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 7 PTAR1
    addVec(1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 8 IDLE

    // Reset state.
    #40;
    check("reset {bus,oe,busy,req,wr,err}", {LpcBusOut, LpcBusOe, Busy, RegReq, RegWr, SyncErr},
          {4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge LpcClock);
    PciReset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge LpcClock);
      AddrHit   = vecs[i].hit;
      Opcode    = vecs[i].op;
      RegAck    = vecs[i].ack;
      RegRdData = vecs[i].rd;
      @(posedge LpcClock); #1;
      check($sformatf("vec %0d {bus,oe,busy,req,wr,err}", i),
            {LpcBusOut, LpcBusOe, Busy, RegReq, (vecs[i].req ? RegWr : 1'b0), SyncErr},
            {vecs[i].bus, vecs[i].oe, vecs[i].busy, vecs[i].req, vecs[i].wr, vecs[i].err});
    end
    @(negedge LpcClock);
    AddrHit = 1'b0; RegAck = 1'b0;

    // Timeout: eight wait nibbles, error SYNC, FF data, late ack ignored.
    runRead(-1, 8'h00, 1'b1, -1);
    expBus.delete();
    for (int i = 0; i < 8; i++) expBus.push_back(4'h6);
    expBus.push_back(4'hA); expBus.push_back(4'hF); expBus.push_back(4'hF); expBus.push_back(4'hF);
    checkSeq("timeout");
    check("timeout SyncErr pulses", errPulses, 1);
    check("timeout RegReq high at error", reqAtErr, 0);

    // Ack on the timeout edge wins.
    runRead(8, 8'h5A, 1'b0, -1);
    expBus.delete();
    for (int i = 0; i < 8; i++) expBus.push_back(4'h6);
    expBus.push_back(4'h0); expBus.push_back(4'hA); expBus.push_back(4'h5); expBus.push_back(4'hF);
    checkSeq("ack at timeout");
    check("ack at timeout SyncErr pulses", errPulses, 0);

    // Abort during SYNC_WAIT, then a clean cycle.
    runRead(-1, 8'h00, 1'b0, 3);
    expBus.delete();
    for (int i = 0; i < 3; i++) expBus.push_back(4'h6);
    checkSeq("abort");
    runRead(1, 8'hC3, 1'b0, -1);
    expBus.delete();
    expBus.push_back(4'h6); expBus.push_back(4'h0); expBus.push_back(4'h3);
    expBus.push_back(4'hC); expBus.push_back(4'hF);
    checkSeq("after abort");

    // Reset asserted during DATA0.
    @(negedge LpcClock);
    AddrHit = 1'b1; Opcode = 1'b0;
    @(negedge LpcClock);
    AddrHit = 1'b0; RegAck = 1'b1; RegRdData = 8'h96;
    @(negedge LpcClock);
    RegAck = 1'b0;
    repeat (3) @(posedge LpcClock);
    #1;
    check("DATA0 before reset {bus,oe}", {LpcBusOut, LpcBusOe}, {4'h6, 1'b1});
    #3;
    PciReset = 1'b0;
    #1;
    check("async reset {bus,oe,busy,req,wr,err}", {LpcBusOut, LpcBusOe, Busy, RegReq, RegWr, SyncErr},
          {4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge LpcClock);
    PciReset = 1'b1;

    // Normal read after reset.
    runRead(1, 8'h42, 1'b0, -1);
    expBus.delete();
    expBus.push_back(4'h6); expBus.push_back(4'h0); expBus.push_back(4'h2);
    expBus.push_back(4'h4); expBus.push_back(4'hF);
    checkSeq("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
